ex_mem_skid_reg: RTL
====================

// Module: ex_mem_skid_reg
// PURPOSE
//  Pipeline boundary between the Execute stage (ALU) and the Memory stage.
//  Captures ALU result, store data and write-back control from Execute, then presents them to Memory.
//  Uses a 2-entry skid buffer with valid/ready handshake, so a Memory-side stall (ready_m low)
//  never creates a combinational path back into Execute.
//  Supports a synchronous flush for branch mispredict / bne redirect.
// PARAMETERS
//  DATA_WIDTH  32  width of ALU result, store data and PC+4
//  REG_AW      5   register-file address width (rd)
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous, active-low reset
//  valid_e      in   1           Execute presents a valid instruction
//  ready_e      out  1           buffer can accept; registered (state != FULL)
//  alu_out_e    in   DATA_WIDTH  ALU result
//  wdata_e      in   DATA_WIDTH  store data (forwarded rs2)
//  pc_plus4_e   in   DATA_WIDTH  PC+4 for JAL/JALR write-back
//  rd_e         in   REG_AW      destination register
//  regwrite_e   in   1           write-back enable
//  memwrite_e   in   1           data-memory write enable
//  resultsrc_e  in   2           write-back mux select
//  flush        in   1           synchronous kill of all held entries
//  valid_m      out  1           head entry valid toward Memory
//  ready_m      in   1           Memory consumes head this cycle
//  alu_out_m / wdata_m / pc_plus4_m / rd_m / resultsrc_m  out  widths as _e  head payload
//  regwrite_m   out  1           regwrite of head, forced 0 when !valid_m
//  memwrite_m   out  1           memwrite of head, forced 0 when !valid_m
// BEHAVIOUR
//  - Handshakes:
//    - acc_in = valid_e & ready_e.
//    - acc_out = valid_m & ready_m.
//    - Data transfers only on these; valid_e/payload may change freely while !ready_e.
//  - State machine, encoded 2 bits: EMPTY, ONE (main valid), FULL (main+skid valid).
//    - EMPTY: acc_in -> ONE, main<=in.
//    - ONE:
//      - acc_in & acc_out -> ONE, main<=in.
//      - acc_in & !acc_out -> FULL, skid<=in.
//      - !acc_in & acc_out -> EMPTY.
//      - otherwise hold.
//    - FULL (ready_e=0): acc_out -> ONE, main<=skid; else hold.
//  - valid_m = (state != EMPTY); outputs always drive the main entry.
//  - ready_e = (state != FULL); depends only on registered state, never on ready_m.
//  - Latency: an instruction accepted at edge N is visible on *_m after edge N (1 cycle).
//    Throughput is 1/cycle while ready_m=1. Order is strictly FIFO; no entry is duplicated or lost.
//  - flush has priority over all transitions:
//    - Next state is EMPTY.
//    - An acc_in in the same cycle is discarded.
//    - acc_out still completes that cycle (Memory already sampled it).
//  - Reset (async, any time, including mid-transfer):
//    - state=EMPTY; valid_m=0; ready_e=1.
//    - All payload registers are 0; regwrite_m=memwrite_m=0.
//  - Payload registers load only on the transitions above; they are not cleared on flush.
//    Control outputs are gated by valid_m instead.
// CONFIGURATION
//  EX_MEM_STALL_CNT_EN defined:
//    - Adds output stall_cnt[15:0].
//    - Increments each cycle valid_m & !ready_m; saturates at 16'hFFFF.
//    - Cleared by rst_n only.
//  Not defined: port and counter absent; behaviour otherwise identical.
// TESTING
//  1. Reset mid-FULL: fill 2 entries, drop rst_n -> same instant valid_m=0, ready_e=1, regwrite_m=0.
//  2. Streaming: ready_m=1, valid_e=1, alu_out_e=1,2,3,4 on consecutive cycles
//     -> alu_out_m=1,2,3,4 one cycle later, ready_e never low.
//  3. Backpressure: ready_m=0, send A=0x10, B=0x20, then C=0x30 held
//     -> ready_e=0 after B, C not taken.
//     Raise ready_m -> A, B, C emerge in order, no duplicates.
//  4. Flush with acc_in: state ONE (rd=5), flush=1 and valid_e=1 (rd=7) same cycle
//     -> next cycle valid_m=0, memwrite_m=0; rd 7 never appears.
//  5. Simultaneous in/out in ONE: head 0xAA with ready_m=1, new 0xBB with valid_e=1
//     -> next cycle state ONE, alu_out_m=0xBB.
//  6. Stall counter (macro on): hold valid_m=1, ready_m=0 for 5 cycles
//     -> stall_cnt=5; preload to 16'hFFFE and stall 3 cycles -> stays 16'hFFFF.

Source files
------------

// File: rtl/ex_mem_skid_reg.sv
// ============================================================================
// ex_mem_skid_reg
//   Execute -> Memory pipeline boundary built as a 2-entry skid buffer.
//   The main entry always drives the Memory-side outputs. The skid entry
//   catches one extra instruction when Memory stalls, so ready_e is purely
//   registered (state != FULL) and no combinational path runs from ready_m
//   back into Execute. A synchronous flush empties the buffer.
//
//   Optional feature (macro EX_MEM_STALL_CNT_EN): adds a saturating 16-bit
//   counter of cycles where valid_m is high and ready_m is low.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   valid_e / ready_e     Execute-side handshake (ready_e registered)
//   alu_out_e, wdata_e,
//   pc_plus4_e, rd_e,
//   regwrite_e,
//   memwrite_e,
//   resultsrc_e           payload from Execute
//   flush                 synchronous kill of all held entries
//   valid_m / ready_m     Memory-side handshake
//   alu_out_m, wdata_m,
//   pc_plus4_m, rd_m,
//   resultsrc_m           head payload toward Memory
//   regwrite_m,
//   memwrite_m            head write enables, forced 0 when !valid_m
//   stall_cnt             (EX_MEM_STALL_CNT_EN only) Memory stall cycles
// ============================================================================
module ex_mem_skid_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_e,
    output logic                  ready_e,
    input  logic [DATA_WIDTH-1:0] alu_out_e,
    input  logic [DATA_WIDTH-1:0] wdata_e,
    input  logic [DATA_WIDTH-1:0] pc_plus4_e,
    input  logic [REG_AW-1:0]     rd_e,
    input  logic                  regwrite_e,
    input  logic                  memwrite_e,
    input  logic [1:0]            resultsrc_e,
    input  logic                  flush,
    output logic                  valid_m,
    input  logic                  ready_m,
    output logic [DATA_WIDTH-1:0] alu_out_m,
    output logic [DATA_WIDTH-1:0] wdata_m,
    output logic [DATA_WIDTH-1:0] pc_plus4_m,
    output logic [REG_AW-1:0]     rd_m,
    output logic [1:0]            resultsrc_m,
`ifdef EX_MEM_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic                  regwrite_m,
    output logic                  memwrite_m
);

    // Packed payload layout: {alu_out, wdata, pc_plus4, rd, regwrite, memwrite, resultsrc}
    localparam int PW = 3*DATA_WIDTH + REG_AW + 4;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic [PW-1:0] in_pkt;
    logic          acc_in, acc_out;
    logic          head_regwrite, head_memwrite;

    assign in_pkt = {alu_out_e, wdata_e, pc_plus4_e, rd_e,
                     regwrite_e, memwrite_e, resultsrc_e};

    // ------------------------------------------------------------------
    // State and payload registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and payload-load logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (acc_in) begin
                    state_d = ONE;
                    main_d  = in_pkt;
                end
            end
            ONE: begin
                if (acc_in && acc_out) begin
                    main_d = in_pkt;
                end else if (acc_in) begin
                    state_d = FULL;
                    skid_d  = in_pkt;
                end else if (acc_out) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (acc_out) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush discards any same-cycle capture; the head handed to Memory
        // this cycle has already been sampled there, so nothing to undo.
        // Payload is left stale and hidden behind valid_m.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (from registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        valid_m = (state_q != EMPTY);
        ready_e = (state_q != FULL);
    end

    assign acc_in  = valid_e & ready_e;
    assign acc_out = valid_m & ready_m;

    assign {alu_out_m, wdata_m, pc_plus4_m, rd_m,
            head_regwrite, head_memwrite, resultsrc_m} = main_q;

    // Stale payload must never cause a write downstream.
    assign regwrite_m = head_regwrite & valid_m;
    assign memwrite_m = head_memwrite & valid_m;

`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_m && !ready_m && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
